uart_msg_streamer: RTL and testbench
====================================

Name: uart_msg_streamer

Overview:
- Parametrised successor to the fixed "Hello World" UART sender.
- Holds a writable message buffer of DEPTH characters and streams the first msg_len entries out of a built-in UART serialiser when triggered.
- Frame format, baud divider, inter-character gap, repeat and abort are all configurable.
- Sits between control logic (button or CPU-side strobe) and the board uartTx pin.

Parameters:
- CLK_DIV, 234: clk cycles per UART bit (≥2).
- DATA_BITS, 8: data bits per frame, 5..8, sent LSB first; buffer entries are 8 bits, unused upper bits are ignored.
- PARITY, 0: 0 = none, 1 = odd, 2 = even.
- STOP_BITS, 1: 1 or 2.
- DEPTH, 16: buffer entries (≥1); AW = $clog2(DEPTH), LW = $clog2(DEPTH+1).
- GAP_CYCLES, 0: idle-high cycles inserted after every stop bit except after the final character of a non-repeating pass.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low.
- start  in  1  level-sampled trigger; acted on only in IDLE.
- abort  in  1  request stop at next frame boundary; sticky until honoured.
- repeat_en  in  1  when 1, loop message continuously; sampled at end of each pass.
- msg_len  in  LW  characters to send; latched on accepted start; values >DEPTH clamp to DEPTH.
- wr_en  in  1  buffer write strobe.
- wr_addr  in  AW  buffer write address.
- wr_data  in  8  buffer write data.
- tx  out  1  UART line, idle high.
- busy  out  1  high from accepted start until return to IDLE.
- done  out  1  one-cycle pulse on normal completion of a pass.
- char_strobe  out  1  one-cycle pulse on the first cycle of each start bit.
- char_idx  out  AW  index of the character currently on the line.

Behaviour:
- Reset (async, rst_n=0): tx=1, busy=0, done=0, char_strobe=0, char_idx=0, state=IDLE, abort latch cleared, baud/bit counters=0. Buffer contents are not reset. A reset mid-frame forces tx high immediately.
- States: IDLE, LOAD, START, DATA, PAR, STOP, GAP.
- IDLE:
  - start=1 and clamped msg_len≠0: latch length, idx=0, busy=1, go to LOAD.
  - start=1 and msg_len=0: done pulses next cycle, busy stays 0.
- LOAD: one cycle; synchronous buffer read of [idx] into the shift register; go to START.
- START: tx=0 for CLK_DIV cycles; char_strobe=1 on its first cycle; char_idx=idx.
- DATA: DATA_BITS bits, each CLK_DIV cycles, LSB first.
- PAR (skipped when PARITY=0): even parity = XOR of data bits; odd parity = its inverse.
- STOP: tx=1 for STOP_BITS*CLK_DIV cycles. At the end of STOP:
  - abort pending: go to IDLE, busy=0, no done pulse, abort latch cleared.
  - else if idx = len-1: done pulses; repeat_en=1 → idx=0, GAP (or LOAD if GAP_CYCLES=0); repeat_en=0 → IDLE, busy=0 in the same cycle done=1.
  - else: idx+1, GAP (or LOAD if GAP_CYCLES=0).
- GAP: tx=1 for GAP_CYCLES cycles, then LOAD. An abort pending at GAP exit goes to IDLE.
- Per-character period = 1 + (1 + DATA_BITS + (PARITY≠0) + STOP_BITS)*CLK_DIV + GAP_CYCLES (gap omitted after the last character when not repeating).
- Latency: start sampled high at edge N → LOAD at N+1 → tx low from edge N+2.
- Writes are accepted at any time. A write and read of the same address in the same cycle returns the old data (read-first). Writes during busy affect characters not yet loaded.
- start, msg_len and repeat_en changes while busy do not disturb the current pass; repeat_en is only consulted at end of pass.
- abort asserted in IDLE is ignored and not latched. abort never truncates a frame, so tx never glitches mid-character.
- Simultaneous end-of-pass and abort: abort wins; no done pulse, busy drops.

Test Plan:
- CLK_DIV=4, 8N1, GAP=2; buffer "Hi"; msg_len=2; start one cycle → tx low 2 cycles after start. 'H'=0x48 bits 0,0,0,1,0,0,1,0, each 4 cycles. Second start bit 43 cycles after first. done 1 cycle after second stop ends, busy falls the same cycle, char_strobe pulses twice with idx 0,1.
- PARITY=2, DATA_BITS=8, byte 0x07 → parity bit 1. PARITY=1, same byte → parity bit 0. DATA_BITS=7, byte 0xFF → 7 ones, bit 7 not sent.
- repeat_en=1, msg_len=3 → idx sequence 0,1,2,0,1,2…, done each pass. Drop repeat_en mid-pass → stops after the current pass ends.
- abort during DATA of char 1 of 4 → char 1 completes fully, tx stays high afterwards, busy falls at end of its stop, no done, char_strobe count=2.
- msg_len=0 → single done pulse, tx never low. msg_len=DEPTH+5 → exactly DEPTH characters sent.
- rst_n low during DATA bit 3 → tx=1 and busy=0 immediately. After release, new start sends from idx 0 with a correct frame. Write to addr 1 during char 0 → new value transmitted as char 1.

Source files
------------

// File: rtl/uart_msg_streamer_if.sv
// Control, buffer-write and status bundle for uart_msg_streamer.
// Widths are derived from DEPTH so that the bus and the streamer always agree.
interface uart_msg_streamer_if #(
    parameter int DEPTH = 16
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int LW = $clog2(DEPTH + 1);

    logic          start;
    logic          abort;
    logic          repeat_en;
    logic [LW-1:0] msg_len;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [7:0]    wr_data;
    logic          tx;
    logic          busy;
    logic          done;
    logic          char_strobe;
    logic [AW-1:0] char_idx;

    modport master (
        output start, abort, repeat_en, msg_len, wr_en, wr_addr, wr_data,
        input  tx, busy, done, char_strobe, char_idx
    );

    modport slave (
        input  start, abort, repeat_en, msg_len, wr_en, wr_addr, wr_data,
        output tx, busy, done, char_strobe, char_idx
    );
endinterface

// File: rtl/uart_msg_streamer.sv
// Streams the first msg_len bytes of a writable buffer out of a UART serialiser,
// with configurable framing, inter-character gap, repeat and frame-boundary abort.
module uart_msg_streamer #(
    parameter int CLK_DIV    = 234,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int DEPTH      = 16,
    parameter int GAP_CYCLES = 0
) (
    input logic                clk,
    input logic                rst_n,
    uart_msg_streamer_if.slave bus
);
    localparam int AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int LW       = $clog2(DEPTH + 1);
    localparam int STOP_LEN = STOP_BITS * CLK_DIV;
    localparam int MAXC     = (STOP_LEN > GAP_CYCLES) ? STOP_LEN : GAP_CYCLES;
    localparam int CW       = $clog2(MAXC + 1);

    localparam logic [CW-1:0] BAUD_LAST = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] STOP_LAST = CW'(STOP_LEN - 1);
    localparam logic [CW-1:0] GAP_LAST  = CW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam logic [2:0]    BIT_LAST  = 3'(DATA_BITS - 1);
    localparam logic [7:0]    DATA_MASK = 8'((1 << DATA_BITS) - 1);
    localparam logic [LW-1:0] DEPTH_L   = LW'(DEPTH);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_START = 3'd2;
    localparam logic [2:0] S_DATA  = 3'd3;
    localparam logic [2:0] S_PAR   = 3'd4;
    localparam logic [2:0] S_STOP  = 3'd5;
    localparam logic [2:0] S_GAP   = 3'd6;
    localparam logic [2:0] S_NEXT  = (GAP_CYCLES > 0) ? S_GAP : S_LOAD;

    logic [7:0]    mem [DEPTH];
    logic [2:0]    state, state_d;
    logic [CW-1:0] cnt, cnt_d;
    logic [2:0]    bit_cnt, bit_cnt_d;
    logic [7:0]    shreg, shreg_d;
    logic          par_bit, par_bit_d;
    logic [AW-1:0] idx, idx_d;
    logic [LW-1:0] len, len_d;
    logic          abort_q, abort_d;
    logic          tx_q, tx_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          strobe_q, strobe_d;
    logic [AW-1:0] char_idx_q, char_idx_d;
    logic [LW-1:0] len_clamp;
    logic [7:0]    rd_byte;
    logic          abort_now;
    logic          last_char;

    // Read-first buffer: a same-cycle write at idx is seen only by later loads.
    always_ff @(posedge clk) begin
        if (bus.wr_en && (32'(bus.wr_addr) < DEPTH))
            mem[bus.wr_addr] <= bus.wr_data;
    end

    assign len_clamp = (bus.msg_len > DEPTH_L) ? DEPTH_L : bus.msg_len;
    assign rd_byte   = mem[idx] & DATA_MASK;
    assign abort_now = abort_q | bus.abort;
    assign last_char = (LW'(idx) + LW'(1)) == len;

    // Outputs are registered from next-state values so tx tracks the state with no lag.
    always_comb begin
        state_d    = state;
        cnt_d      = cnt;
        bit_cnt_d  = bit_cnt;
        shreg_d    = shreg;
        par_bit_d  = par_bit;
        idx_d      = idx;
        len_d      = len;
        tx_d       = tx_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        strobe_d   = 1'b0;
        char_idx_d = char_idx_q;
        abort_d    = abort_q | (bus.abort && (state != S_IDLE));
        case (state)
            S_IDLE: begin
                tx_d    = 1'b1;
                busy_d  = 1'b0;
                abort_d = 1'b0;
                if (bus.start) begin
                    if (len_clamp != '0) begin
                        len_d   = len_clamp;
                        idx_d   = '0;
                        busy_d  = 1'b1;
                        state_d = S_LOAD;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            S_LOAD: begin
                shreg_d    = rd_byte;
                par_bit_d  = (PARITY == 1) ? ~(^rd_byte) : (^rd_byte);
                cnt_d      = '0;
                tx_d       = 1'b0;
                strobe_d   = 1'b1;
                char_idx_d = idx;
                state_d    = S_START;
            end
            S_START: begin
                if (cnt == BAUD_LAST) begin
                    cnt_d     = '0;
                    bit_cnt_d = '0;
                    tx_d      = shreg[0];
                    state_d   = S_DATA;
                end else begin
                    cnt_d = cnt + CW'(1);
                end
            end
            S_DATA: begin
                if (cnt == BAUD_LAST) begin
                    cnt_d   = '0;
                    shreg_d = shreg >> 1;
                    if (bit_cnt == BIT_LAST) begin
                        if (PARITY != 0) begin
                            tx_d    = par_bit;
                            state_d = S_PAR;
                        end else begin
                            tx_d    = 1'b1;
                            state_d = S_STOP;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt + 3'd1;
                        tx_d      = shreg[1];
                    end
                end else begin
                    cnt_d = cnt + CW'(1);
                end
            end
            S_PAR: begin
                if (cnt == BAUD_LAST) begin
                    cnt_d   = '0;
                    tx_d    = 1'b1;
                    state_d = S_STOP;
                end else begin
                    cnt_d = cnt + CW'(1);
                end
            end
            S_STOP: begin
                if (cnt == STOP_LAST) begin
                    cnt_d = '0;
                    tx_d  = 1'b1;
                    // Abort beats end-of-pass: no done pulse when both coincide.
                    if (abort_now) begin
                        state_d = S_IDLE;
                        busy_d  = 1'b0;
                        abort_d = 1'b0;
                    end else if (last_char) begin
                        done_d = 1'b1;
                        idx_d  = '0;
                        if (bus.repeat_en) begin
                            state_d = S_NEXT;
                        end else begin
                            state_d = S_IDLE;
                            busy_d  = 1'b0;
                        end
                    end else begin
                        idx_d   = idx + AW'(1);
                        state_d = S_NEXT;
                    end
                end else begin
                    cnt_d = cnt + CW'(1);
                end
            end
            S_GAP: begin
                if (cnt == GAP_LAST) begin
                    cnt_d = '0;
                    if (abort_now) begin
                        state_d = S_IDLE;
                        busy_d  = 1'b0;
                        abort_d = 1'b0;
                    end else begin
                        state_d = S_LOAD;
                    end
                end else begin
                    cnt_d = cnt + CW'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                tx_d    = 1'b1;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            cnt        <= '0;
            bit_cnt    <= '0;
            shreg      <= '0;
            par_bit    <= 1'b0;
            idx        <= '0;
            len        <= '0;
            abort_q    <= 1'b0;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            strobe_q   <= 1'b0;
            char_idx_q <= '0;
        end else begin
            state      <= state_d;
            cnt        <= cnt_d;
            bit_cnt    <= bit_cnt_d;
            shreg      <= shreg_d;
            par_bit    <= par_bit_d;
            idx        <= idx_d;
            len        <= len_d;
            abort_q    <= abort_d;
            tx_q       <= tx_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            strobe_q   <= strobe_d;
            char_idx_q <= char_idx_d;
        end
    end

    assign bus.tx          = tx_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.char_strobe = strobe_q;
    assign bus.char_idx    = char_idx_q;
endmodule

// File: tb/tb_uart_msg_streamer.sv
// Directed bench: three streamer configurations, traced cycle by cycle on the
// falling clock edge and compared against hand-computed line timelines.
module tb_uart_msg_streamer;
    localparam int TN = 300;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    uart_msg_streamer_if #(.DEPTH(4)) ifa ();
    uart_msg_streamer_if #(.DEPTH(4)) ifb ();
    uart_msg_streamer_if #(.DEPTH(4)) ifc ();

    // A: 8N1, gap 2.  B: 8E2, no gap.  C: 7O1, no gap.
    uart_msg_streamer #(.CLK_DIV(4), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1),
                        .DEPTH(4), .GAP_CYCLES(2)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa));
    uart_msg_streamer #(.CLK_DIV(4), .DATA_BITS(8), .PARITY(2), .STOP_BITS(2),
                        .DEPTH(4), .GAP_CYCLES(0)) dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb));
    uart_msg_streamer #(.CLK_DIV(4), .DATA_BITS(7), .PARITY(1), .STOP_BITS(1),
                        .DEPTH(4), .GAP_CYCLES(0)) dut_c (.clk(clk), .rst_n(rst_n), .bus(ifc));

    int total = 0;
    int bad   = 0;

    logic       a_tx   [0:TN-1];
    logic       a_stb  [0:TN-1];
    logic       a_done [0:TN-1];
    logic       a_busy [0:TN-1];
    logic [1:0] a_idx  [0:TN-1];
    logic       b_tx   [0:TN-1];
    logic       b_done [0:TN-1];
    logic       b_busy [0:TN-1];
    logic       c_tx   [0:TN-1];
    logic       c_done [0:TN-1];

    task automatic wr(input int which, input logic [1:0] addr, input logic [7:0] data);
        case (which)
            0: begin ifa.wr_en = 1'b1; ifa.wr_addr = addr; ifa.wr_data = data; end
            1: begin ifb.wr_en = 1'b1; ifb.wr_addr = addr; ifb.wr_data = data; end
            default: begin ifc.wr_en = 1'b1; ifc.wr_addr = addr; ifc.wr_data = data; end
        endcase
        @(negedge clk);
        ifa.wr_en = 1'b0;
        ifb.wr_en = 1'b0;
        ifc.wr_en = 1'b0;
    endtask

    // Caller raises start at a falling edge (t=0); trace index t is the t-th falling edge after.
    task automatic capture(input int n, input int abort_at, input int repoff_at,
                           input int wr_at, input logic [7:0] wr_val);
        for (int t = 1; t < n; t++) begin
            @(negedge clk);
            if (t == 1) begin
                ifa.start = 1'b0;
                ifb.start = 1'b0;
                ifc.start = 1'b0;
            end
            a_tx[t] = ifa.tx;  a_stb[t] = ifa.char_strobe; a_done[t] = ifa.done;
            a_busy[t] = ifa.busy; a_idx[t] = ifa.char_idx;
            b_tx[t] = ifb.tx;  b_done[t] = ifb.done; b_busy[t] = ifb.busy;
            c_tx[t] = ifc.tx;  c_done[t] = ifc.done;
            ifa.abort = (t == abort_at);
            if (t == repoff_at) ifa.repeat_en = 1'b0;
            if (t == wr_at) begin
                ifa.wr_en = 1'b1; ifa.wr_addr = 2'd1; ifa.wr_data = wr_val;
            end else begin
                ifa.wr_en = 1'b0;
            end
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        total++; if (ifa.tx !== 1'b1) begin bad++; $display("FAIL reset_tx_a: got %b want 1", ifa.tx); end
        total++; if (ifa.busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", ifa.busy); end
        total++; if (ifa.done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", ifa.done); end
        total++; if (ifa.char_strobe !== 1'b0) begin bad++; $display("FAIL reset_strobe: got %b want 0", ifa.char_strobe); end
        total++; if (ifa.char_idx !== 2'd0) begin bad++; $display("FAIL reset_idx: got %0d want 0", ifa.char_idx); end
        total++; if ({ifb.tx, ifc.tx} !== 2'b11) begin bad++; $display("FAIL reset_tx_bc: got %b want 11", {ifb.tx, ifc.tx}); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_hello;
        logic [7:0] h, i;
        int ns, nd;
        h = 8'h48; i = 8'h69;
        wr(0, 2'd0, h);
        wr(0, 2'd1, i);
        ifa.msg_len = 3'd2;
        ifa.start = 1'b1;
        capture(120, -1, -1, -1, 8'h00);
        total++; if ({a_tx[1], a_busy[1]} !== 2'b11) begin bad++; $display("FAIL hello_load: tx,busy got %b want 11", {a_tx[1], a_busy[1]}); end
        total++; if ({a_tx[2], a_stb[2]} !== 2'b01) begin bad++; $display("FAIL hello_first_start: tx,strobe got %b want 01", {a_tx[2], a_stb[2]}); end
        total++; if (a_idx[2] !== 2'd0) begin bad++; $display("FAIL hello_idx0: got %0d want 0", a_idx[2]); end
        for (int k = 0; k < 8; k++) begin
            total++; if (a_tx[8 + 4*k] !== h[k]) begin bad++; $display("FAIL hello_char0_bit%0d: got %b want %b", k, a_tx[8 + 4*k], h[k]); end
        end
        total++; if ({a_tx[40], a_tx[42], a_tx[43], a_tx[44]} !== 4'b1111) begin bad++; $display("FAIL hello_stop_gap: got %b want 1111", {a_tx[40], a_tx[42], a_tx[43], a_tx[44]}); end
        total++; if ({a_tx[45], a_stb[45], a_idx[45]} !== 4'b0101) begin bad++; $display("FAIL hello_second_start: tx,strobe,idx got %b want 0101", {a_tx[45], a_stb[45], a_idx[45]}); end
        for (int k = 0; k < 8; k++) begin
            total++; if (a_tx[51 + 4*k] !== i[k]) begin bad++; $display("FAIL hello_char1_bit%0d: got %b want %b", k, a_tx[51 + 4*k], i[k]); end
        end
        total++; if ({a_busy[84], a_done[84], a_tx[83]} !== 3'b101) begin bad++; $display("FAIL hello_last_stop: busy,done,tx got %b want 101", {a_busy[84], a_done[84], a_tx[83]}); end
        total++; if ({a_done[85], a_busy[85]} !== 2'b10) begin bad++; $display("FAIL hello_done: done,busy got %b want 10", {a_done[85], a_busy[85]}); end
        ns = 0; nd = 0;
        for (int t = 1; t < 120; t++) begin ns += int'(a_stb[t]); nd += int'(a_done[t]); end
        total++; if (ns !== 2) begin bad++; $display("FAIL hello_strobe_count: got %0d want 2", ns); end
        total++; if (nd !== 1) begin bad++; $display("FAIL hello_done_count: got %0d want 1", nd); end
    endtask

    task automatic test_parity;
        logic [7:0] v;
        v = 8'h07;
        wr(1, 2'd0, v);
        wr(2, 2'd0, v);
        wr(2, 2'd1, 8'hFF);
        ifb.msg_len = 3'd1;
        ifc.msg_len = 3'd2;
        ifb.start = 1'b1;
        ifc.start = 1'b1;
        capture(100, -1, -1, -1, 8'h00);
        for (int k = 0; k < 8; k++) begin
            total++; if (b_tx[8 + 4*k] !== v[k]) begin bad++; $display("FAIL even_bit%0d: got %b want %b", k, b_tx[8 + 4*k], v[k]); end
        end
        total++; if (b_tx[40] !== 1'b1) begin bad++; $display("FAIL even_parity: got %b want 1", b_tx[40]); end
        total++; if ({b_tx[44], b_tx[48]} !== 2'b11) begin bad++; $display("FAIL even_two_stops: got %b want 11", {b_tx[44], b_tx[48]}); end
        total++; if ({b_busy[49], b_done[49], b_done[50], b_busy[50]} !== 4'b1010) begin bad++; $display("FAIL even_done: got %b want 1010", {b_busy[49], b_done[49], b_done[50], b_busy[50]}); end
        for (int k = 0; k < 7; k++) begin
            total++; if (c_tx[8 + 4*k] !== v[k]) begin bad++; $display("FAIL odd_c0_bit%0d: got %b want %b", k, c_tx[8 + 4*k], v[k]); end
        end
        total++; if (c_tx[36] !== 1'b0) begin bad++; $display("FAIL odd_parity0: got %b want 0", c_tx[36]); end
        total++; if ({c_tx[40], c_tx[45]} !== 2'b10) begin bad++; $display("FAIL odd_stop_then_start: got %b want 10", {c_tx[40], c_tx[45]}); end
        for (int k = 0; k < 7; k++) begin
            total++; if (c_tx[49 + 4*k] !== 1'b1) begin bad++; $display("FAIL seven_ones_bit%0d: got %b want 1", k, c_tx[49 + 4*k]); end
        end
        total++; if (c_tx[77] !== 1'b0) begin bad++; $display("FAIL odd_parity1_bit7_dropped: got %b want 0", c_tx[77]); end
        total++; if ({c_tx[81], c_done[82], c_done[83]} !== 3'b101) begin bad++; $display("FAIL odd_done: got %b want 101", {c_tx[81], c_done[82], c_done[83]}); end
    endtask

    task automatic test_repeat;
        int ns, nd, nl;
        wr(0, 2'd0, 8'h61);
        wr(0, 2'd1, 8'h62);
        wr(0, 2'd2, 8'h63);
        ifa.msg_len = 3'd3;
        ifa.repeat_en = 1'b1;
        ifa.start = 1'b1;
        capture(280, -1, 150, -1, 8'h00);
        for (int k = 0; k < 6; k++) begin
            total++; if ({a_stb[2 + 43*k], a_idx[2 + 43*k]} !== {1'b1, 2'(k % 3)}) begin
                bad++; $display("FAIL repeat_strobe%0d: strobe,idx got %b want %b", k, {a_stb[2 + 43*k], a_idx[2 + 43*k]}, {1'b1, 2'(k % 3)});
            end
        end
        total++; if ({a_done[128], a_busy[128]} !== 2'b11) begin bad++; $display("FAIL repeat_done_pass1: done,busy got %b want 11", {a_done[128], a_busy[128]}); end
        total++; if ({a_done[257], a_busy[257]} !== 2'b10) begin bad++; $display("FAIL repeat_done_pass2: done,busy got %b want 10", {a_done[257], a_busy[257]}); end
        ns = 0; nd = 0; nl = 0;
        for (int t = 1; t < 280; t++) begin
            ns += int'(a_stb[t]); nd += int'(a_done[t]);
            if (t > 257 && a_tx[t] !== 1'b1) nl++;
        end
        total++; if (ns !== 6) begin bad++; $display("FAIL repeat_strobe_count: got %0d want 6", ns); end
        total++; if (nd !== 2) begin bad++; $display("FAIL repeat_done_count: got %0d want 2", nd); end
        total++; if (nl !== 0) begin bad++; $display("FAIL repeat_idle_after: non-high cycles got %0d want 0", nl); end
    endtask

    task automatic test_abort;
        logic [7:0] b;
        int ns, nd, nl;
        b = 8'h62;
        wr(0, 2'd3, 8'h64);
        ifa.msg_len = 3'd4;
        ifa.start = 1'b1;
        capture(150, 60, -1, -1, 8'h00);
        for (int k = 0; k < 8; k++) begin
            total++; if (a_tx[51 + 4*k] !== b[k]) begin bad++; $display("FAIL abort_char1_bit%0d: got %b want %b", k, a_tx[51 + 4*k], b[k]); end
        end
        total++; if ({a_busy[84], a_busy[85]} !== 2'b10) begin bad++; $display("FAIL abort_busy_fall: got %b want 10", {a_busy[84], a_busy[85]}); end
        ns = 0; nd = 0; nl = 0;
        for (int t = 1; t < 150; t++) begin
            ns += int'(a_stb[t]); nd += int'(a_done[t]);
            if (t > 80 && a_tx[t] !== 1'b1) nl++;
        end
        total++; if (ns !== 2) begin bad++; $display("FAIL abort_strobe_count: got %0d want 2", ns); end
        total++; if (nd !== 0) begin bad++; $display("FAIL abort_no_done: got %0d want 0", nd); end
        total++; if (nl !== 0) begin bad++; $display("FAIL abort_line_high: non-high cycles got %0d want 0", nl); end
    endtask

    task automatic test_zero_len;
        int nb, nd, nl;
        ifa.msg_len = 3'd0;
        ifa.start = 1'b1;
        capture(20, -1, -1, -1, 8'h00);
        total++; if (a_done[1] !== 1'b1) begin bad++; $display("FAIL zero_done: got %b want 1", a_done[1]); end
        nb = 0; nd = 0; nl = 0;
        for (int t = 1; t < 20; t++) begin
            nb += int'(a_busy[t]); nd += int'(a_done[t]); nl += int'(!a_tx[t]);
        end
        total++; if (nd !== 1) begin bad++; $display("FAIL zero_done_count: got %0d want 1", nd); end
        total++; if (nb !== 0) begin bad++; $display("FAIL zero_busy: busy cycles got %0d want 0", nb); end
        total++; if (nl !== 0) begin bad++; $display("FAIL zero_tx: low cycles got %0d want 0", nl); end
    endtask

    task automatic test_clamp;
        int ns;
        ifa.msg_len = 3'd7;
        ifa.start = 1'b1;
        capture(200, -1, -1, -1, 8'h00);
        ns = 0;
        for (int t = 1; t < 200; t++) ns += int'(a_stb[t]);
        total++; if (ns !== 4) begin bad++; $display("FAIL clamp_char_count: got %0d want 4", ns); end
        total++; if ({a_stb[131], a_idx[131]} !== 3'b111) begin bad++; $display("FAIL clamp_last_idx: strobe,idx got %b want 111", {a_stb[131], a_idx[131]}); end
        total++; if ({a_done[171], a_busy[171], a_busy[170]} !== 3'b101) begin bad++; $display("FAIL clamp_done: got %b want 101", {a_done[171], a_busy[171], a_busy[170]}); end
    endtask

    task automatic test_reset_midframe;
        ifa.msg_len = 3'd2;
        ifa.start = 1'b1;
        for (int t = 1; t <= 19; t++) begin
            @(negedge clk);
            if (t == 1) ifa.start = 1'b0;
        end
        // Data bit 3 of 0x61 is 0, so the line is low just before reset.
        total++; if ({ifa.tx, ifa.busy} !== 2'b01) begin bad++; $display("FAIL midframe_pre: tx,busy got %b want 01", {ifa.tx, ifa.busy}); end
        rst_n = 1'b0;
        #1;
        total++; if ({ifa.tx, ifa.busy} !== 2'b10) begin bad++; $display("FAIL midframe_async: tx,busy got %b want 10", {ifa.tx, ifa.busy}); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_write_during;
        logic [7:0] a0, n1;
        a0 = 8'h61; n1 = 8'h55;
        ifa.msg_len = 3'd2;
        ifa.start = 1'b1;
        capture(100, -1, -1, 20, n1);
        total++; if ({a_stb[2], a_idx[2]} !== 3'b100) begin bad++; $display("FAIL wr_restart_idx: strobe,idx got %b want 100", {a_stb[2], a_idx[2]}); end
        for (int k = 0; k < 8; k++) begin
            total++; if (a_tx[8 + 4*k] !== a0[k]) begin bad++; $display("FAIL wr_char0_bit%0d: got %b want %b", k, a_tx[8 + 4*k], a0[k]); end
        end
        for (int k = 0; k < 8; k++) begin
            total++; if (a_tx[51 + 4*k] !== n1[k]) begin bad++; $display("FAIL wr_char1_bit%0d: got %b want %b", k, a_tx[51 + 4*k], n1[k]); end
        end
        total++; if ({a_done[85], a_busy[85]} !== 2'b10) begin bad++; $display("FAIL wr_done: done,busy got %b want 10", {a_done[85], a_busy[85]}); end
    endtask

    initial begin
        rst_n = 1'b1;
        ifa.start = 1'b0; ifa.abort = 1'b0; ifa.repeat_en = 1'b0; ifa.msg_len = '0;
        ifa.wr_en = 1'b0; ifa.wr_addr = '0; ifa.wr_data = '0;
        ifb.start = 1'b0; ifb.abort = 1'b0; ifb.repeat_en = 1'b0; ifb.msg_len = '0;
        ifb.wr_en = 1'b0; ifb.wr_addr = '0; ifb.wr_data = '0;
        ifc.start = 1'b0; ifc.abort = 1'b0; ifc.repeat_en = 1'b0; ifc.msg_len = '0;
        ifc.wr_en = 1'b0; ifc.wr_addr = '0; ifc.wr_data = '0;
        test_reset();
        test_hello();
        test_parity();
        test_repeat();
        test_abort();
        test_zero_len();
        test_clamp();
        test_reset_midframe();
        test_write_during();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
